// File: rtl/sram_sync_clr.sv
// Synchronous work/video RAM with a CPU read/write port, a read-only video
// port and a built-in clear engine that fills the array with FILL.
module sram_sync_clr #(
    parameter int                DATA_W         = 4,
    parameter int                ADDR_W         = 10,
    parameter logic [DATA_W-1:0] FILL           = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs_n,
    input  logic              cpu_we_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    input  logic              clr_req,
    output logic              busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              cpu_acc;
    logic              cpu_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign cpu_ready = (state == IDLE);
    assign busy      = (state == CLEAR);
    assign cpu_acc   = cpu_ready & ~cpu_cs_n;
    assign cpu_rd    = cpu_acc & cpu_we_n;

    // Single write port shared by the clear engine and the CPU; the two are
    // never active together because CPU access is only accepted in IDLE.
    // Writes are suppressed while reset is held so the array stays untouched.
    assign wr_en   = ~reset & (busy | (cpu_acc & ~cpu_we_n));
    assign wr_addr = busy ? clr_addr : cpu_addr;
    assign wr_data = busy ? FILL : cpu_din;

    // Clear-engine FSM: walks clr_addr through the whole array once, then idles
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    // clr_addr wraps to zero after LAST, ready for the next run
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST)
                        state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Memory array write; no reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read ports; both are read-first against a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout  <= '0;
            cpu_valid <= 1'b0;
            vid_dout  <= '0;
        end else begin
            vid_dout  <= mem[vid_addr];
            cpu_valid <= cpu_rd;
            if (cpu_rd)
                cpu_dout <= mem[cpu_addr];
        end
    end

endmodule

// File: tb/tb_sram_sync_clr.sv
// Randomized self-checking bench for sram_sync_clr with a behavioural memory
// model. A second instance covers the no-clear-on-reset configuration.
module tb_sram_sync_clr;

    localparam int DW = 4;
    localparam int AW = 10;
    localparam int N  = 1024;
    localparam logic [DW-1:0] FILLV = 4'h5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_cs_n = 1'b1, cpu_we_n = 1'b1;
    logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic          clr_req = 1'b0;
    logic [DW-1:0] cpu_dout, vid_dout;
    logic          cpu_valid, cpu_ready, busy;

    logic          reset2 = 1'b1;
    logic          cs2_n = 1'b1, we2_n = 1'b1;
    logic [AW-1:0] addr2 = '0, vaddr2 = '0;
    logic [DW-1:0] din2 = '0;
    logic [DW-1:0] dout2, vdout2;
    logic          valid2, ready2, busy2;

    int checks = 0;
    int errors = 0;

    // behavioural model: array plus count of clear writes still outstanding
    logic [DW-1:0] m_mem [N];
    int            m_clr_left;
    logic [DW-1:0] m_dout, m_vid;
    logic          m_valid;

    always #5 clk = ~clk;

    sram_sync_clr #(.DATA_W(DW), .ADDR_W(AW), .FILL(FILLV), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .cpu_cs_n(cpu_cs_n), .cpu_we_n(cpu_we_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .vid_addr(vid_addr),
        .vid_dout(vid_dout), .clr_req(clr_req), .busy(busy)
    );

    sram_sync_clr #(.DATA_W(DW), .ADDR_W(AW), .FILL(FILLV), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .cpu_cs_n(cs2_n), .cpu_we_n(we2_n),
        .cpu_addr(addr2), .cpu_din(din2), .cpu_dout(dout2),
        .cpu_valid(valid2), .cpu_ready(ready2), .vid_addr(vaddr2),
        .vid_dout(vdout2), .clr_req(1'b0), .busy(busy2)
    );

    // advance one clock, updating the model from the inputs presented this cycle
    task automatic tick();
        logic          acc;
        logic [DW-1:0] vid_old;
        vid_old = m_mem[vid_addr];
        acc = (m_clr_left == 0) && !cpu_cs_n;
        if (reset) begin
            m_dout = '0; m_vid = '0; m_valid = 1'b0; m_clr_left = N;
        end else begin
            m_vid   = vid_old;
            m_valid = acc && cpu_we_n;
            if (acc && cpu_we_n) m_dout = m_mem[cpu_addr];
            if (m_clr_left > 0) begin
                m_mem[N - m_clr_left] = FILLV;
                m_clr_left--;
            end else begin
                if (acc && !cpu_we_n) m_mem[cpu_addr] = cpu_din;
                if (clr_req) m_clr_left = N;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (cpu_dout !== 4'h0) begin errors++; $display("FAIL reset_cpu_dout got %h exp 0", cpu_dout); end
        checks++; if (vid_dout !== 4'h0) begin errors++; $display("FAIL reset_vid_dout got %h exp 0", vid_dout); end
        checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cpu_valid); end
        checks++; if (busy !== 1'b1 || cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_busy got busy=%b ready=%b exp 1/0", busy, cpu_ready); end
        reset = 1'b0;
    endtask

    task automatic test_clear_on_reset();
        int n = 0;
        int bad_ready = 0;
        while (busy === 1'b1 && n < 1100) begin
            if (cpu_ready !== 1'b0) bad_ready++;
            vid_addr = 10'($urandom_range(0, N - 1));
            tick(); n++;
            if (!$isunknown(m_vid)) begin
                checks++; if (vid_dout !== m_vid) begin errors++; $display("FAIL clr_vid addr=%h got %h exp %h", vid_addr, vid_dout, m_vid); end
            end
        end
        checks++; if (n != N) begin errors++; $display("FAIL clr_cycles got %0d exp %0d", n, N); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL clr_ready_high got %0d cycles exp 0", bad_ready); end
        cpu_cs_n = 1'b0; cpu_we_n = 1'b1; cpu_addr = 10'h000; tick();
        checks++; if (cpu_valid !== 1'b1 || cpu_dout !== FILLV) begin errors++; $display("FAIL clr_rd0 got v=%b d=%h exp 1/%h", cpu_valid, cpu_dout, FILLV); end
        cpu_addr = 10'h3FF; tick();
        checks++; if (cpu_valid !== 1'b1 || cpu_dout !== FILLV) begin errors++; $display("FAIL clr_rd3ff got v=%b d=%h exp 1/%h", cpu_valid, cpu_dout, FILLV); end
        cpu_cs_n = 1'b1; tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] pat [8] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
        for (int i = 0; i < 8; i++) begin
            cpu_cs_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 10'(i); cpu_din = pat[i];
            tick();
            checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL wr_valid i=%0d got %b exp 0", i, cpu_valid); end
        end
        for (int i = 0; i < 8; i++) begin
            cpu_we_n = 1'b1; cpu_addr = 10'(i);
            tick();
            checks++; if (cpu_valid !== 1'b1 || cpu_dout !== pat[i]) begin errors++; $display("FAIL b2b_rd i=%0d got v=%b d=%h exp 1/%h", i, cpu_valid, cpu_dout, pat[i]); end
        end
        cpu_cs_n = 1'b1; tick();
        checks++; if (cpu_valid !== 1'b0 || cpu_dout !== 4'hF) begin errors++; $display("FAIL rd_hold got v=%b d=%h exp 0/f", cpu_valid, cpu_dout); end
    endtask

    task automatic test_collision();
        cpu_cs_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 10'h155; cpu_din = 4'h3; tick();
        cpu_din = 4'hC; vid_addr = 10'h155; tick();
        checks++; if (vid_dout !== 4'h3) begin errors++; $display("FAIL coll_old got %h exp 3", vid_dout); end
        cpu_cs_n = 1'b1; tick();
        checks++; if (vid_dout !== 4'hC) begin errors++; $display("FAIL coll_new got %h exp c", vid_dout); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cpu_cs_n = 1'($urandom_range(0, 1));
            cpu_we_n = 1'($urandom_range(0, 1));
            cpu_addr = 10'($urandom_range(0, 15));
            cpu_din  = 4'($urandom_range(0, 15));
            vid_addr = 10'($urandom_range(0, 15));
            tick();
            checks++;
            if (cpu_valid !== m_valid || cpu_dout !== m_dout || vid_dout !== m_vid) begin
                errors++;
                $display("FAIL rand i=%0d got v=%b d=%h vd=%h exp v=%b d=%h vd=%h", i, cpu_valid, cpu_dout, vid_dout, m_valid, m_dout, m_vid);
            end
        end
        cpu_cs_n = 1'b1; tick();
    endtask

    task automatic test_clr_with_write();
        int n = 0;
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL t4_ready got %b exp 1", cpu_ready); end
        cpu_cs_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 10'h010; cpu_din = 4'h9; clr_req = 1'b1; vid_addr = 10'h010;
        tick();
        cpu_cs_n = 1'b1; clr_req = 1'b0;
        while (busy === 1'b1 && n < 1100) begin
            clr_req  = (n == 100);
            vid_addr = (n == 0) ? 10'h010 : 10'($urandom_range(0, N - 1));
            tick(); n++;
            if (n == 1) begin
                checks++; if (vid_dout !== 4'h9) begin errors++; $display("FAIL t4_wr_landed got %h exp 9", vid_dout); end
            end else if (n % 64 == 0) begin
                checks++; if (vid_dout !== m_vid) begin errors++; $display("FAIL t4_vid got %h exp %h", vid_dout, m_vid); end
            end
        end
        clr_req = 1'b0;
        checks++; if (n != N) begin errors++; $display("FAIL t4_cycles got %0d exp %0d", n, N); end
        cpu_cs_n = 1'b0; cpu_we_n = 1'b1; cpu_addr = 10'h010; tick();
        checks++; if (cpu_valid !== 1'b1 || cpu_dout !== FILLV) begin errors++; $display("FAIL t4_rd got v=%b d=%h exp 1/%h", cpu_valid, cpu_dout, FILLV); end
        cpu_cs_n = 1'b1; tick();
    endtask

    task automatic test_busy_reset();
        int n = 0;
        int bad = 0;
        cpu_cs_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 10'h020; cpu_din = 4'hA; tick();
        cpu_we_n = 1'b1; tick();
        checks++; if (cpu_dout !== 4'hA) begin errors++; $display("FAIL t5_pre got %h exp a", cpu_dout); end
        cpu_cs_n = 1'b1; clr_req = 1'b1; tick();
        clr_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cpu_cs_n = 1'b0; cpu_we_n = 1'b1; cpu_addr = 10'($urandom_range(0, N - 1));
            if (cpu_ready !== 1'b0) bad++;
            tick();
            if (cpu_valid !== 1'b0 || cpu_dout !== 4'hA) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t5_blocked got %0d bad cycles exp 0", bad); end
        cpu_cs_n = 1'b1; reset = 1'b1; tick();
        reset = 1'b0;
        checks++; if (cpu_dout !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL t5_reset got d=%h busy=%b exp 0/1", cpu_dout, busy); end
        while (busy === 1'b1 && n < 1100) begin tick(); n++; end
        checks++; if (n != N) begin errors++; $display("FAIL t5_restart_cycles got %0d exp %0d", n, N); end
        cpu_cs_n = 1'b0; cpu_addr = 10'h3FF; tick();
        checks++; if (cpu_valid !== m_valid || cpu_dout !== m_dout) begin errors++; $display("FAIL t5_rd got v=%b d=%h exp %b/%h", cpu_valid, cpu_dout, m_valid, m_dout); end
        cpu_cs_n = 1'b1; tick();
    endtask

    task automatic test_no_clear();
        reset2 = 1'b1; tick();
        reset2 = 1'b0;
        checks++; if (busy2 !== 1'b0 || ready2 !== 1'b1) begin errors++; $display("FAIL t6_state got busy=%b ready=%b exp 0/1", busy2, ready2); end
        checks++; if (dout2 !== 4'h0 || vdout2 !== 4'h0 || valid2 !== 1'b0) begin errors++; $display("FAIL t6_outs got d=%h vd=%h v=%b exp 0/0/0", dout2, vdout2, valid2); end
        cs2_n = 1'b0; we2_n = 1'b0; addr2 = 10'h02A; din2 = 4'h6; tick();
        we2_n = 1'b1; vaddr2 = 10'h02A; tick();
        checks++; if (valid2 !== 1'b1 || dout2 !== 4'h6 || vdout2 !== 4'h6) begin errors++; $display("FAIL t6_rd got v=%b d=%h vd=%h exp 1/6/6", valid2, dout2, vdout2); end
        cs2_n = 1'b1; tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_mem[i] = 'x;
        m_clr_left = 0; m_dout = '0; m_vid = '0; m_valid = 1'b0;
        test_reset();
        test_clear_on_reset();
        test_write_read();
        test_collision();
        test_random();
        test_clr_with_write();
        test_busy_reset();
        test_no_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
